ysyx_axi_arbiter_n: RTL and testbench

YSYX_AXI_ARBITER_N -- requirements
Module: ysyx_axi_arbiter_n
Interface
REQ-001 SHALL have parameter NM, default 2, number of requesting masters (2..8).
REQ-002 SHALL have parameter ADDR_W, default 32, address width; DATA_W, default 32, master-side data width (bus side fixed 64).
REQ-003 clk  in  1  sole clock, rising edge.
REQ-004 rst  in  1  reset, asynchronous, active-low.
REQ-005 m_req  in  NM  per-master request, held until m_done.
REQ-006 m_we  in  NM  per-master write(1)/read(0).
REQ-007 m_addr  in  NM*ADDR_W  packed per-master byte address.
REQ-008 m_wdata  in  NM*DATA_W  packed per-master write data, lane 0 aligned.
REQ-009 m_strb  in  NM*4  packed per-master byte mask, 4'h1/4'h3/4'hf.
REQ-010 m_done  out  NM  one-hot, 1-cycle pulse, transaction complete.
REQ-011 m_rdata  out  DATA_W  read data, valid with m_done.
REQ-012 m_err  out  1  nonzero rresp/bresp, valid with m_done.
REQ-013 io_master_ar{addr,size,valid}  out  ADDR_W/3/1; io_master_arready  in  1.
REQ-014 io_master_r{data,resp,valid}  in  64/2/1; io_master_rready  out  1.
REQ-015 io_master_aw{addr,size,valid}  out  ADDR_W/3/1; io_master_awready  in  1.
REQ-016 io_master_w{data,strb,valid,last}  out  64/8/1/1; io_master_wready  in  1.
REQ-017 io_master_b{resp,valid}  in  2/1; io_master_bready  out  1.
Function
REQ-018 States IDLE, AR, R, AW_W, B; one outstanding transaction, single beat: arlen/awlen=0, burst INCR, id=0 (tied).
REQ-019 IDLE: if any m_req, latch winner index, its we/addr/wdata/strb; go AR (read) or AW_W (write) next cycle; grant latency 1 cycle.
REQ-020 AR: arvalid=1 until arready, then R; R: rready=1, on rvalid capture rdata/rresp, pulse m_done[winner], go IDLE.
REQ-021 AW_W: awvalid and wvalid both raised on entry, each dropped independently after its handshake; go B when both done (either order or same cycle).
REQ-022 B: bready=1; on bvalid pulse m_done[winner], m_err=(bresp!=0), go IDLE.
REQ-023 size from strb: 4'h1->0, 4'h3->1, 4'hf->2, other->2.
REQ-024 Write lanes: byte offset o=addr[2:0]; wdata=(wdata<<8*addr[1:0]) replicated in both 32-bit halves; wstrb=strb<<o; wlast=wvalid.
REQ-025 Read lanes: m_rdata=(addr[2]?rdata[63:32]:rdata[31:0])>>8*addr[1:0], unused upper bits zero.
REQ-026 Request latched in IDLE is frozen; master input changes mid-transaction SHALL have no effect; m_req dropped mid-transaction still completes, m_done still pulses.
REQ-027 rvalid/bvalid arriving in a state not expecting it SHALL be ignored; no m_done.
REQ-028 Back-to-back: m_req re-sampled in IDLE cycle after m_done; minimum 4 cycles per transaction with zero-wait slave.
Reset
REQ-029 While rst=0: state IDLE, all valids 0, m_done 0, m_err 0, m_rdata 0, rready/bready 0, round-robin pointer 0; takes effect without clock.
REQ-030 rst asserted mid-transaction SHALL abandon it with no m_done; release resumes from IDLE.
Configuration
REQ-031 YSYX_ARB_RR_EN defined: round-robin, search starts at last winner+1 modulo NM, pointer updates at grant.
REQ-032 YSYX_ARB_RR_EN undefined: fixed priority, lowest index wins; pointer logic absent.
Verification
REQ-033 NM=2, m0 read 0x8000_0004 strb 4'hf, rdata=64'hAABBCCDD_11223344 -> araddr 0x80000004, arsize 2, m_rdata 0xAABBCCDD, m_done=2'b01.
REQ-034 m1 write 0x8000_0003 strb 4'h1 wdata 0x5A -> awsize 0, wstrb 8'h08, wdata 64'h5A000000_5A000000, m_done=2'b10 after bvalid.
REQ-035 awready 3 cycles before wready, then reverse order -> both complete, exactly one m_done each, no duplicate aw/w handshake.
REQ-036 Both m_req held 4 transactions, RR_EN on -> grant order 0,1,0,1; RR_EN off -> 0,0,0,0.
REQ-037 rst low during R state, then release -> no m_done, arvalid 0, next request served normally; bresp=2'b10 -> m_err=1 with m_done.

---
 rtl/ysyx_axi_arbiter_n.sv | 243 ++++++++++++++++++++++++
 tb/tb_ysyx_axi_arbiter_n.sv | 325 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ysyx_axi_arbiter_n.sv
// N-master arbiter onto one AXI4 port: one outstanding single-beat transaction, 32-bit master lanes onto a 64-bit bus.
// Define YSYX_ARB_RR_EN for round-robin arbitration; otherwise fixed priority (lowest index wins).
module ysyx_axi_arbiter_n #(
  parameter int NM     = 2,
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [NM-1:0]        m_req,
  input  logic [NM-1:0]        m_we,
  input  logic [NM*ADDR_W-1:0] m_addr,
  input  logic [NM*DATA_W-1:0] m_wdata,
  input  logic [NM*4-1:0]      m_strb,
  output logic [NM-1:0]        m_done,
  output logic [DATA_W-1:0]    m_rdata,
  output logic                 m_err,
  output logic [ADDR_W-1:0]    io_master_araddr,
  output logic [2:0]           io_master_arsize,
  output logic [7:0]           io_master_arlen,
  output logic [1:0]           io_master_arburst,
  output logic [3:0]           io_master_arid,
  output logic                 io_master_arvalid,
  input  logic                 io_master_arready,
  input  logic [63:0]          io_master_rdata,
  input  logic [1:0]           io_master_rresp,
  input  logic                 io_master_rvalid,
  output logic                 io_master_rready,
  output logic [ADDR_W-1:0]    io_master_awaddr,
  output logic [2:0]           io_master_awsize,
  output logic [7:0]           io_master_awlen,
  output logic [1:0]           io_master_awburst,
  output logic [3:0]           io_master_awid,
  output logic                 io_master_awvalid,
  input  logic                 io_master_awready,
  output logic [63:0]          io_master_wdata,
  output logic [7:0]           io_master_wstrb,
  output logic                 io_master_wvalid,
  output logic                 io_master_wlast,
  input  logic                 io_master_wready,
  input  logic [1:0]           io_master_bresp,
  input  logic                 io_master_bvalid,
  output logic                 io_master_bready
);

  localparam int IW = (NM > 1) ? $clog2(NM) : 1;

  typedef enum logic [2:0] {
    S_IDLE,
    S_AR,
    S_R,
    S_AW_W,
    S_B
  } state_t;

  state_t              r_state;
  logic [IW-1:0]       r_winIdx;
  logic                r_we;
  logic [ADDR_W-1:0]   r_addr;
  logic [DATA_W-1:0]   r_wdata;
  logic [3:0]          r_strb;
  logic                r_arvalid;
  logic                r_rready;
  logic                r_awvalid;
  logic                r_wvalid;
  logic                r_bready;
  logic [NM-1:0]       r_done;
  logic                r_err;
  logic [DATA_W-1:0]   r_rdata;

  logic                w_anyReq;
  logic [IW-1:0]       w_winIdx;
  int                  w_sel;
  logic [NM-1:0]       w_winOneHot;
  logic [2:0]          w_size;
  logic [31:0]         w_wd32;
  logic [31:0]         w_wdShift;
  logic [7:0]          w_wstrb;
  logic [31:0]         w_rdWord;
  logic [31:0]         w_rdShift;
  logic [DATA_W-1:0]   w_rdLane;

  assign w_anyReq    = |m_req;
  assign w_sel       = int'(w_winIdx);
  assign w_winOneHot = {{(NM-1){1'b0}}, 1'b1} << r_winIdx;

`ifdef YSYX_ARB_RR_EN
  logic [IW-1:0] r_rrPtr;

  // Search begins one past the previous winner so every requester gets a turn.
  always_comb begin
    int   idx;
    logic found;
    idx      = 0;
    found    = 1'b0;
    w_winIdx = '0;
    for (int k = 0; k < NM; k++) begin
      idx = (int'(r_rrPtr) + k) % NM;
      if (!found && m_req[idx]) begin
        w_winIdx = IW'(idx);
        found    = 1'b1;
      end
    end
  end
`else
  always_comb begin
    w_winIdx = '0;
    for (int i = NM - 1; i >= 0; i--) begin
      if (m_req[i]) w_winIdx = IW'(i);
    end
  end
`endif

  always_comb begin
    case (r_strb)
      4'h1:    w_size = 3'd0;
      4'h3:    w_size = 3'd1;
      default: w_size = 3'd2;
    endcase
  end

  generate
    if (DATA_W == 32) begin : g_dw32
      assign w_wd32   = r_wdata;
      assign w_rdLane = w_rdShift;
    end else if (DATA_W > 32) begin : g_dwWide
      assign w_wd32   = r_wdata[31:0];
      assign w_rdLane = {{(DATA_W-32){1'b0}}, w_rdShift};
    end else begin : g_dwNarrow
      assign w_wd32   = {{(32-DATA_W){1'b0}}, r_wdata};
      assign w_rdLane = w_rdShift[DATA_W-1:0];
    end
  endgenerate

  // Lane steering: write data is duplicated into both halves so the strobe alone selects the bytes.
  assign w_wdShift = w_wd32 << {r_addr[1:0], 3'b000};
  assign w_wstrb   = {4'b0000, r_strb} << r_addr[2:0];
  assign w_rdWord  = r_addr[2] ? io_master_rdata[63:32] : io_master_rdata[31:0];
  assign w_rdShift = w_rdWord >> {r_addr[1:0], 3'b000};

  assign io_master_araddr  = r_addr;
  assign io_master_arsize  = w_size;
  assign io_master_arlen   = 8'd0;
  assign io_master_arburst = 2'b01;
  assign io_master_arid    = 4'd0;
  assign io_master_arvalid = r_arvalid;
  assign io_master_rready  = r_rready;
  assign io_master_awaddr  = r_addr;
  assign io_master_awsize  = w_size;
  assign io_master_awlen   = 8'd0;
  assign io_master_awburst = 2'b01;
  assign io_master_awid    = 4'd0;
  assign io_master_awvalid = r_awvalid;
  assign io_master_wdata   = {w_wdShift, w_wdShift};
  assign io_master_wstrb   = w_wstrb;
  assign io_master_wvalid  = r_wvalid;
  assign io_master_wlast   = r_wvalid;
  assign io_master_bready  = r_bready;
  assign m_done            = r_done;
  assign m_rdata           = r_rdata;
  assign m_err             = r_err;

  // IDLE skips the cycle in which m_done is showing, so a master still holding m_req is not re-granted.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state   <= S_IDLE;
      r_winIdx  <= '0;
      r_we      <= 1'b0;
      r_addr    <= '0;
      r_wdata   <= '0;
      r_strb    <= '0;
      r_arvalid <= 1'b0;
      r_rready  <= 1'b0;
      r_awvalid <= 1'b0;
      r_wvalid  <= 1'b0;
      r_bready  <= 1'b0;
      r_done    <= '0;
      r_err     <= 1'b0;
      r_rdata   <= '0;
`ifdef YSYX_ARB_RR_EN
      r_rrPtr   <= '0;
`endif
    end else begin
      r_done <= '0;
      case (r_state)
        S_IDLE: begin
          if (w_anyReq && (r_done == '0)) begin
            r_winIdx <= w_winIdx;
            r_we     <= m_we[w_winIdx];
            r_addr   <= m_addr[w_sel*ADDR_W +: ADDR_W];
            r_wdata  <= m_wdata[w_sel*DATA_W +: DATA_W];
            r_strb   <= m_strb[w_sel*4 +: 4];
`ifdef YSYX_ARB_RR_EN
            r_rrPtr  <= (w_sel == NM - 1) ? '0 : w_winIdx + 1'b1;
`endif
            if (m_we[w_winIdx]) begin
              r_awvalid <= 1'b1;
              r_wvalid  <= 1'b1;
              r_state   <= S_AW_W;
            end else begin
              r_arvalid <= 1'b1;
              r_state   <= S_AR;
            end
          end
        end
        S_AR: begin
          if (io_master_arready) begin
            r_arvalid <= 1'b0;
            r_rready  <= 1'b1;
            r_state   <= S_R;
          end
        end
        S_R: begin
          if (io_master_rvalid) begin
            r_rready <= 1'b0;
            r_rdata  <= w_rdLane;
            r_err    <= |io_master_rresp;
            r_done   <= w_winOneHot;
            r_state  <= S_IDLE;
          end
        end
        S_AW_W: begin
          if (r_awvalid && io_master_awready) r_awvalid <= 1'b0;
          if (r_wvalid && io_master_wready)   r_wvalid  <= 1'b0;
          if ((!r_awvalid || io_master_awready) && (!r_wvalid || io_master_wready)) begin
            r_bready <= 1'b1;
            r_state  <= S_B;
          end
        end
        S_B: begin
          if (io_master_bvalid) begin
            r_bready <= 1'b0;
            r_err    <= |io_master_bresp;
            r_done   <= w_winOneHot;
            r_state  <= S_IDLE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ysyx_axi_arbiter_n.sv
// Directed testbench for ysyx_axi_arbiter_n: vector table plus hand-written grant-order, stray-response and reset sequences.
// Expectations follow YSYX_ARB_RR_EN the same way the design does.
module tb_ysyx_axi_arbiter_n;

  localparam int NM = 2;
  localparam int AW = 32;
  localparam int DW = 32;

  logic           clk;
  logic           rst;
  logic [NM-1:0]  m_req;
  logic [NM-1:0]  m_we;
  logic [NM*AW-1:0] m_addr;
  logic [NM*DW-1:0] m_wdata;
  logic [NM*4-1:0]  m_strb;
  logic [NM-1:0]  m_done;
  logic [DW-1:0]  m_rdata;
  logic           m_err;
  logic [AW-1:0]  io_master_araddr;
  logic [2:0]     io_master_arsize;
  logic [7:0]     io_master_arlen;
  logic [1:0]     io_master_arburst;
  logic [3:0]     io_master_arid;
  logic           io_master_arvalid;
  logic           io_master_arready;
  logic [63:0]    io_master_rdata;
  logic [1:0]     io_master_rresp;
  logic           io_master_rvalid;
  logic           io_master_rready;
  logic [AW-1:0]  io_master_awaddr;
  logic [2:0]     io_master_awsize;
  logic [7:0]     io_master_awlen;
  logic [1:0]     io_master_awburst;
  logic [3:0]     io_master_awid;
  logic           io_master_awvalid;
  logic           io_master_awready;
  logic [63:0]    io_master_wdata;
  logic [7:0]     io_master_wstrb;
  logic           io_master_wvalid;
  logic           io_master_wlast;
  logic           io_master_wready;
  logic [1:0]     io_master_bresp;
  logic           io_master_bvalid;
  logic           io_master_bready;

  ysyx_axi_arbiter_n #(.NM(NM), .ADDR_W(AW), .DATA_W(DW)) dut (
    .clk(clk), .rst(rst),
    .m_req(m_req), .m_we(m_we), .m_addr(m_addr), .m_wdata(m_wdata), .m_strb(m_strb),
    .m_done(m_done), .m_rdata(m_rdata), .m_err(m_err),
    .io_master_araddr(io_master_araddr), .io_master_arsize(io_master_arsize),
    .io_master_arlen(io_master_arlen), .io_master_arburst(io_master_arburst),
    .io_master_arid(io_master_arid), .io_master_arvalid(io_master_arvalid),
    .io_master_arready(io_master_arready),
    .io_master_rdata(io_master_rdata), .io_master_rresp(io_master_rresp),
    .io_master_rvalid(io_master_rvalid), .io_master_rready(io_master_rready),
    .io_master_awaddr(io_master_awaddr), .io_master_awsize(io_master_awsize),
    .io_master_awlen(io_master_awlen), .io_master_awburst(io_master_awburst),
    .io_master_awid(io_master_awid), .io_master_awvalid(io_master_awvalid),
    .io_master_awready(io_master_awready),
    .io_master_wdata(io_master_wdata), .io_master_wstrb(io_master_wstrb),
    .io_master_wvalid(io_master_wvalid), .io_master_wlast(io_master_wlast),
    .io_master_wready(io_master_wready),
    .io_master_bresp(io_master_bresp), .io_master_bvalid(io_master_bvalid),
    .io_master_bready(io_master_bready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        we;
    int          master;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  strb;
    logic [63:0] slvRdata;
    logic [1:0]  slvResp;
    int          awLat;
    int          wLat;
    bit          scramble;
    logic [2:0]  expSize;
    logic [63:0] expWdata;
    logic [7:0]  expWstrb;
    logic [31:0] expRdata;
    logic        expErr;
    logic [1:0]  expDone;
  } vec_t;

  vec_t vecs [8];
  logic [1:0] expOrder [4];

  int nChecks;
  int nFail;

  logic [NM-1:0] obsDone;
  logic [31:0]   obsRdata;
  logic          obsErr;
  logic [31:0]   obsAddr;
  logic [2:0]    obsSize;
  logic [63:0]   obsWdata;
  logic [7:0]    obsWstrb;
  logic          obsWlast;
  int            arCnt, awCnt, wCnt, obsCycles;
  logic          timedOut;
  logic [63:0]   slvRdata;
  logic [1:0]    slvResp;
  logic          seenR;

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    nChecks++;
    if (act !== exp) begin
      nFail++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic checkResetOutputs(input string tag);
    checkOutput({tag, "_m_done"},  64'(m_done), 64'h0);
    checkOutput({tag, "_m_err"},   64'(m_err), 64'h0);
    checkOutput({tag, "_m_rdata"}, 64'(m_rdata), 64'h0);
    checkOutput({tag, "_arvalid"}, 64'(io_master_arvalid), 64'h0);
    checkOutput({tag, "_awvalid"}, 64'(io_master_awvalid), 64'h0);
    checkOutput({tag, "_wvalid"},  64'(io_master_wvalid), 64'h0);
    checkOutput({tag, "_rready"},  64'(io_master_rready), 64'h0);
    checkOutput({tag, "_bready"},  64'(io_master_bready), 64'h0);
  endtask

  task automatic slaveIdle();
    io_master_arready = 1'b0;
    io_master_awready = 1'b0;
    io_master_wready  = 1'b0;
    io_master_rvalid  = 1'b0;
    io_master_bvalid  = 1'b0;
  endtask

  // Reactive slave: runs until m_done shows or the cycle budget expires.
  task automatic driveSlave(input int awLat, input int wLat, input bit scramble);
    int awWait, wWait;
    bit fin, scr;
    awWait = 0; wWait = 0; fin = 1'b0; scr = 1'b0;
    arCnt = 0; awCnt = 0; wCnt = 0; obsCycles = 40; timedOut = 1'b1;
    obsDone = '0; obsRdata = '0; obsErr = 1'b0; obsAddr = '0; obsSize = '0;
    obsWdata = '0; obsWstrb = '0; obsWlast = 1'b0;
    for (int c = 0; c < 40 && !fin; c++) begin
      @(negedge clk);
      if (m_done != '0) begin
        fin = 1'b1; timedOut = 1'b0; obsCycles = c + 1;
        obsDone = m_done; obsRdata = m_rdata; obsErr = m_err;
        slaveIdle();
      end else begin
        if (scramble && !scr && (io_master_arvalid || io_master_awvalid || io_master_wvalid)) begin
          scr = 1'b1;
          m_req = '0; m_we = ~m_we; m_addr = {NM{32'h1234_5678}};
          m_wdata = '1; m_strb = {NM{4'h1}};
        end
        io_master_arready = io_master_arvalid;
        if (io_master_arvalid && io_master_arready) begin
          arCnt++; obsAddr = io_master_araddr; obsSize = io_master_arsize;
        end
        if (io_master_awvalid) begin
          io_master_awready = (awWait >= awLat); awWait++;
        end else io_master_awready = 1'b0;
        if (io_master_awvalid && io_master_awready) begin
          awCnt++; obsAddr = io_master_awaddr; obsSize = io_master_awsize;
        end
        if (io_master_wvalid) begin
          io_master_wready = (wWait >= wLat); wWait++;
        end else io_master_wready = 1'b0;
        if (io_master_wvalid && io_master_wready) begin
          wCnt++; obsWdata = io_master_wdata; obsWstrb = io_master_wstrb; obsWlast = io_master_wlast;
        end
        io_master_rvalid = io_master_rready;
        io_master_rdata  = slvRdata;
        io_master_rresp  = slvResp;
        io_master_bvalid = io_master_bready;
        io_master_bresp  = slvResp;
      end
    end
  endtask

  task automatic applyStimulus(input vec_t v, input string tag);
    @(negedge clk);
    m_req = '0;
    m_req[v.master] = 1'b1;
    m_we[v.master] = v.we;
    m_addr[v.master*32 +: 32]  = v.addr;
    m_wdata[v.master*32 +: 32] = v.wdata;
    m_strb[v.master*4 +: 4]    = v.strb;
    slvRdata = v.slvRdata;
    slvResp  = v.slvResp;
    driveSlave(v.awLat, v.wLat, v.scramble);
    m_req = '0;
    checkOutput({tag, "_timeout"}, 64'(timedOut), 64'h0);
    checkOutput({tag, "_done"}, 64'(obsDone), 64'(v.expDone));
    checkOutput({tag, "_err"}, 64'(obsErr), 64'(v.expErr));
    checkOutput({tag, "_addr"}, 64'(obsAddr), 64'(v.addr));
    checkOutput({tag, "_size"}, 64'(obsSize), 64'(v.expSize));
    if (v.we) begin
      checkOutput({tag, "_awcnt"}, 64'(awCnt), 64'd1);
      checkOutput({tag, "_wcnt"}, 64'(wCnt), 64'd1);
      checkOutput({tag, "_arcnt"}, 64'(arCnt), 64'd0);
      checkOutput({tag, "_wdata"}, obsWdata, v.expWdata);
      checkOutput({tag, "_wstrb"}, 64'(obsWstrb), 64'(v.expWstrb));
      checkOutput({tag, "_wlast"}, 64'(obsWlast), 64'd1);
    end else begin
      checkOutput({tag, "_arcnt"}, 64'(arCnt), 64'd1);
      checkOutput({tag, "_awwcnt"}, 64'(awCnt + wCnt), 64'd0);
      checkOutput({tag, "_rdata"}, 64'(obsRdata), 64'(v.expRdata));
    end
    @(negedge clk);
    checkOutput({tag, "_pulse"}, 64'(m_done), 64'h0);
  endtask

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    nChecks = 0; nFail = 0;
    vecs[0] = '{1'b0, 0, 32'h8000_0004, 32'h0, 4'hf, 64'hAABBCCDD_11223344, 2'b00, 0, 0, 1'b0,
                3'd2, 64'h0, 8'h00, 32'hAABBCCDD, 1'b0, 2'b01};
    vecs[1] = '{1'b1, 1, 32'h8000_0003, 32'h5A, 4'h1, 64'h0, 2'b00, 0, 3, 1'b0,
                3'd0, 64'h5A000000_5A000000, 8'h08, 32'h0, 1'b0, 2'b10};
    vecs[2] = '{1'b1, 0, 32'h8000_0006, 32'h1234, 4'h3, 64'h0, 2'b00, 3, 0, 1'b0,
                3'd1, 64'h12340000_12340000, 8'hC0, 32'h0, 1'b0, 2'b01};
    vecs[3] = '{1'b0, 1, 32'h8000_0002, 32'h0, 4'h3, 64'h01234567_89ABCDEF, 2'b00, 0, 0, 1'b1,
                3'd1, 64'h0, 8'h00, 32'h000089AB, 1'b0, 2'b10};
    vecs[4] = '{1'b1, 0, 32'h8000_0000, 32'hDEADBEEF, 4'hf, 64'h0, 2'b10, 0, 0, 1'b1,
                3'd2, 64'hDEADBEEF_DEADBEEF, 8'h0F, 32'h0, 1'b1, 2'b01};
    vecs[5] = '{1'b0, 1, 32'h8000_0007, 32'h0, 4'h1, 64'hCAFE0000_00000000, 2'b11, 0, 0, 1'b0,
                3'd0, 64'h0, 8'h00, 32'h000000CA, 1'b1, 2'b10};
    vecs[6] = '{1'b0, 0, 32'h8000_0001, 32'h0, 4'h7, 64'h00000000_A1B2C3D4, 2'b00, 0, 0, 1'b0,
                3'd2, 64'h0, 8'h00, 32'h00A1B2C3, 1'b0, 2'b01};
    vecs[7] = '{1'b1, 1, 32'h8000_0005, 32'h77, 4'h1, 64'h0, 2'b01, 2, 2, 1'b0,
                3'd0, 64'h00007700_00007700, 8'h20, 32'h0, 1'b1, 2'b10};
`ifdef YSYX_ARB_RR_EN
    expOrder[0] = 2'b01; expOrder[1] = 2'b10; expOrder[2] = 2'b01; expOrder[3] = 2'b10;
`else
    expOrder[0] = 2'b01; expOrder[1] = 2'b01; expOrder[2] = 2'b01; expOrder[3] = 2'b01;
`endif

    m_req = '0; m_we = '0; m_addr = '0; m_wdata = '0; m_strb = '0;
    io_master_rdata = '0; io_master_rresp = '0; io_master_bresp = '0;
    slaveIdle();
    slvRdata = '0; slvResp = '0;

    // Reset is applied and checked before the first clock edge.
    rst = 1'b1;
    #1 rst = 1'b0;
    #1 checkResetOutputs("por");
    repeat (2) @(negedge clk);
    rst = 1'b1;

    // Both masters hold requests across four transactions.
    @(negedge clk);
    m_req = '1; m_we = '0;
    m_addr = {32'h8000_0100, 32'h8000_0000}; m_strb = {4'hf, 4'hf};
    slvRdata = 64'h0; slvResp = 2'b00;
    for (int t = 0; t < 4; t++) begin
      driveSlave(0, 0, 1'b0);
      checkOutput($sformatf("grant%0d", t), 64'(obsDone), 64'(expOrder[t]));
      if (t > 0) checkOutput($sformatf("b2b_cycles%0d", t), 64'(obsCycles), 64'd4);
    end
    m_req = '0;
    repeat (2) @(negedge clk);

    // Stray responses while idle and while waiting on the address channel.
    io_master_rvalid = 1'b1; io_master_bvalid = 1'b1;
    io_master_rdata = '1; io_master_bresp = 2'b00;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      checkOutput($sformatf("stray_idle%0d", c), 64'(m_done), 64'h0);
    end
    m_req[0] = 1'b1; m_we[0] = 1'b0; m_addr[31:0] = 32'h8000_0008; m_strb[3:0] = 4'hf;
    io_master_arready = 1'b0;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      checkOutput($sformatf("stray_ar_done%0d", c), 64'(m_done), 64'h0);
      checkOutput($sformatf("stray_ar_valid%0d", c), 64'(io_master_arvalid), 64'h1);
    end
    io_master_rvalid = 1'b0; io_master_bvalid = 1'b0;
    slvRdata = 64'h13572468_9ABCDEF0; slvResp = 2'b00;
    driveSlave(0, 0, 1'b0);
    m_req = '0;
    checkOutput("stray_done", 64'(obsDone), 64'h1);
    checkOutput("stray_rdata", 64'(obsRdata), 64'h9ABCDEF0);

    for (int i = 0; i < 8; i++) applyStimulus(vecs[i], $sformatf("v%0d", i));

    // Reset while waiting in R: transaction is abandoned.
    @(negedge clk);
    m_req = '0; m_req[0] = 1'b1; m_we[0] = 1'b0; m_addr[31:0] = 32'h8000_0010; m_strb[3:0] = 4'hf;
    seenR = 1'b0;
    for (int c = 0; c < 20 && !seenR; c++) begin
      @(negedge clk);
      io_master_arready = io_master_arvalid;
      if (io_master_rready) seenR = 1'b1;
    end
    checkOutput("rst_reach_R", 64'(seenR), 64'h1);
    io_master_arready = 1'b0;
    #2 rst = 1'b0;
    #1 checkResetOutputs("midR");
    m_req = '0;
    io_master_rvalid = 1'b1;
    for (int c = 0; c < 2; c++) begin
      @(negedge clk);
      checkOutput($sformatf("inrst_done%0d", c), 64'(m_done), 64'h0);
    end
    io_master_rvalid = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      checkOutput($sformatf("postrst_done%0d", c), 64'(m_done), 64'h0);
      checkOutput($sformatf("postrst_arvalid%0d", c), 64'(io_master_arvalid), 64'h0);
    end
    applyStimulus(vecs[0], "recover");

    $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFail);
    $finish;
  end

endmodule
